// File: rtl/des_key_schedule_if.sv
// Handshake and data bundle between the key schedule and its control/consumer side.
// The slave modport is the schedule's view; master is the driving/consuming side.
interface des_key_schedule_if;
    logic        start;
    logic        decrypt;
    logic [55:0] key56;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        done;

    modport master (
        output start, decrypt, key56, subkey_ready,
        input  busy, subkey_valid, subkey, round_idx, done
    );

    modport slave (
        input  start, decrypt, key56, subkey_ready,
        output busy, subkey_valid, subkey, round_idx, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: rotates the PC-1 halves step by step and streams
// one PC-2 subkey per handshake, in forward (K1..K16) or reverse (K16..K1) order.
module des_key_schedule (
    input  logic              clk,
    input  logic              rst_n,
    des_key_schedule_if.slave ks
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state, state_nxt;
    logic [27:0] c_reg, d_reg;
    logic [3:0]  n_reg;
    logic        mode_dec;
    logic        valid_int, busy_int, done_int;
    logic        handshake;
    logic [55:0] cd;
    logic [47:0] subkey_w;

    // Rounds 1, 2, 9 and 16 shift by one position, every other round by two.
    function automatic logic [1:0] shift_amt(input logic [3:0] idx);
        return (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] amt);
        return (amt == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] amt);
        return (amt == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    assign handshake = valid_int && ks.subkey_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ks.start) state_nxt = RUN;
            RUN:     if (handshake && n_reg == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_int = 1'b0;
        busy_int  = 1'b0;
        done_int  = 1'b0;
        case (state)
            RUN: begin
                valid_int = 1'b1;
                busy_int  = 1'b1;
            end
            DONE: begin
                busy_int = 1'b1;
                done_int = 1'b1;
            end
            default: ;
        endcase
    end

    // Decrypt starts at C16||D16, which equals C0||D0 because the forward shifts total 28,
    // and then walks backwards with right rotations; nothing beyond the current C/D is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg    <= '0;
            d_reg    <= '0;
            n_reg    <= '0;
            mode_dec <= 1'b0;
        end else if (state == IDLE && ks.start) begin
            mode_dec <= ks.decrypt;
            n_reg    <= '0;
            c_reg    <= ks.decrypt ? ks.key56[55:28] : rotl(ks.key56[55:28], 2'd1);
            d_reg    <= ks.decrypt ? ks.key56[27:0]  : rotl(ks.key56[27:0], 2'd1);
        end else if (handshake && n_reg != 4'd15) begin
            n_reg <= n_reg + 4'd1;
            if (mode_dec) begin
                c_reg <= rotr(c_reg, shift_amt(4'd15 - n_reg));
                d_reg <= rotr(d_reg, shift_amt(4'd15 - n_reg));
            end else begin
                c_reg <= rotl(c_reg, shift_amt(n_reg + 4'd1));
                d_reg <= rotl(d_reg, shift_amt(n_reg + 4'd1));
            end
        end
    end

    assign cd = {c_reg, d_reg};

    // PC-2 uses FIPS numbering: position p of C||D is bit 56-p, output bit 1 lands on bit 47.
    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey_w[47-i] = cd[56-PC2[i]];
    end

    assign ks.subkey       = subkey_w;
    assign ks.round_idx    = mode_dec ? (4'd15 - n_reg) : n_reg;
    assign ks.subkey_valid = valid_int;
    assign ks.busy         = busy_int;
    assign ks.done         = done_int;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: a reference key-schedule model fills a queue of
// expected {round_idx, subkey} pairs that are compared as the DUT presents keys.
module tb_des_key_schedule;

    localparam logic [55:0] KEY_STD = 56'hF0CCAAF556678F;
    localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_STD  = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

    localparam int CUM_SHIFT [0:15] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};
    localparam int PC2_TB [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic clk;
    logic rst_n;
    des_key_schedule_if ks();

    des_key_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc, done_cyc, first_valid_cyc;
    int hs_count, done_count, stall_cnt;
    bit seen_valid, rand_ready, stall_k8;
    logic [51:0] exp_q[$];
    logic [47:0] got_key [0:15];
    logic [3:0]  got_idx [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Independent model: Kr comes from rotating C0/D0 left by the cumulative shift count.
    function automatic logic [47:0] model_key(input logic [55:0] k56, input int r);
        logic [27:0] c0, d0, c, d;
        logic [55:0] cd, tmp;
        logic [47:0] res;
        int s;
        c0  = k56[55:28];
        d0  = k56[27:0];
        s   = CUM_SHIFT[r] % 28;
        c   = (c0 << s) | (c0 >> (28 - s));
        d   = (d0 << s) | (d0 >> (28 - s));
        cd  = {c, d};
        res = '0;
        for (int i = 0; i < 48; i++) begin
            tmp = cd >> (56 - PC2_TB[i]);
            res = {res[46:0], tmp[0]};
        end
        return res;
    endfunction

    task automatic build_expected(input logic [55:0] key, input logic dec);
        for (int j = 0; j < 16; j++) begin
            int r;
            logic [3:0] ri;
            r  = dec ? 15 - j : j;
            ri = 4'(r);
            exp_q.push_back({ri, model_key(key, r)});
        end
    endtask

    task automatic applyStimulus(input logic [55:0] key, input logic dec);
        hs_count   = 0;
        done_count = 0;
        seen_valid = 1'b0;
        build_expected(key, dec);
        ks.key56   = key;
        ks.decrypt = dec;
        ks.start   = 1'b1;
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        ks.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit check_latency);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (ks.done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) begin
            checkOutput("done_timeout", ks.done, 1'b1);
        end else begin
            checkOutput("busy_with_done", ks.busy, 1'b1);
            checkOutput("first_valid_latency", first_valid_cyc - start_cyc, 1);
            if (check_latency) checkOutput("start_to_done_cycles", done_cyc - start_cyc, 17);
        end
        @(posedge clk);
        #1;
        checkOutput("handshakes", hs_count, 16);
        checkOutput("done_pulses", done_count, 1);
        checkOutput("busy_idle", ks.busy, 1'b0);
        checkOutput("done_idle", ks.done, 1'b0);
        checkOutput("sb_drained", exp_q.size(), 0);
    endtask

    // Presented keys are checked every cycle against the queue head, so stalls must hold steady.
    always @(negedge clk) begin
        logic [51:0] head;
        if (rst_n && ks.done) done_count++;
        if (rst_n && ks.subkey_valid) begin
            if (!seen_valid) begin
                seen_valid      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
                checkOutput("spurious_valid", ks.subkey_valid, 1'b0);
            end else begin
                head = exp_q[0];
                checkOutput("subkey", ks.subkey, head[47:0]);
                checkOutput("round_idx", ks.round_idx, head[51:48]);
                if (ks.subkey_ready) begin
                    head = exp_q.pop_front();
                    if (hs_count < 16) begin
                        got_key[hs_count] = ks.subkey;
                        got_idx[hs_count] = ks.round_idx;
                    end
                    hs_count++;
                end
            end
        end
    end

    initial begin
        ks.subkey_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_k8 && ks.subkey_valid && ks.round_idx == 4'd7 && stall_cnt < 5) begin
                ks.subkey_ready = 1'b0;
                stall_cnt++;
            end else if (rand_ready) begin
                ks.subkey_ready = 1'($urandom_range(0, 1));
            end else begin
                ks.subkey_ready = 1'b1;
            end
        end
    end

    initial begin
        logic [55:0] flat_key;
        logic [47:0] flat_exp;
        rand_ready = 1'b0;
        stall_k8   = 1'b0;
        stall_cnt  = 0;
        ks.start   = 1'b0;
        ks.decrypt = 1'b0;
        ks.key56   = '0;
        rst_n      = 1'b0;

        #12;
        checkOutput("reset_busy", ks.busy, 1'b0);
        checkOutput("reset_valid", ks.subkey_valid, 1'b0);
        checkOutput("reset_done", ks.done, 1'b0);
        checkOutput("reset_subkey", ks.subkey, 48'h0);
        checkOutput("reset_round_idx", ks.round_idx, 4'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] encrypt run, ready held high");
        applyStimulus(KEY_STD, 1'b0);
        wait_done(100, 1'b1);
        checkOutput("enc_k1", got_key[0], K1_STD);
        checkOutput("enc_k1_idx", got_idx[0], 4'd0);
        checkOutput("enc_k2", got_key[1], K2_STD);
        checkOutput("enc_k16", got_key[15], K16_STD);
        checkOutput("enc_k16_idx", got_idx[15], 4'd15);

        $display("[TB] decrypt run started in the idle cycle right after done");
        applyStimulus(KEY_STD, 1'b1);
        wait_done(100, 1'b1);
        checkOutput("dec_first", got_key[0], K16_STD);
        checkOutput("dec_first_idx", got_idx[0], 4'd15);
        checkOutput("dec_last", got_key[15], K1_STD);
        checkOutput("dec_last_idx", got_idx[15], 4'd0);

        $display("[TB] random backpressure with a stall on K8");
        rand_ready = 1'b1;
        stall_k8   = 1'b1;
        stall_cnt  = 0;
        applyStimulus(56'h3A94C2E7F1B05D, 1'b0);
        wait_done(400, 1'b0);
        rand_ready = 1'b0;
        stall_k8   = 1'b0;
        checkOutput("k8_stall_cycles", stall_cnt, 5);

        $display("[TB] start pulsed while running");
        @(posedge clk);
        #1;
        applyStimulus(KEY_STD, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        ks.key56   = 56'hFFFFFFFFFFFFFF;
        ks.decrypt = 1'b1;
        ks.start   = 1'b1;
        @(posedge clk);
        #1;
        ks.start = 1'b0;
        wait_done(100, 1'b1);
        checkOutput("ignored_start_k16", got_key[15], K16_STD);

        $display("[TB] asynchronous reset mid-schedule");
        applyStimulus(KEY_STD, 1'b0);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", ks.busy, 1'b0);
        checkOutput("abort_valid", ks.subkey_valid, 1'b0);
        checkOutput("abort_done", ks.done, 1'b0);
        checkOutput("abort_subkey", ks.subkey, 48'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        checkOutput("abort_no_done", done_count, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(KEY_STD, 1'b0);
        wait_done(100, 1'b1);
        checkOutput("post_reset_k1", got_key[0], K1_STD);
        checkOutput("post_reset_k1_idx", got_idx[0], 4'd0);

        $display("[TB] flat keys in both modes");
        for (int m = 0; m < 4; m++) begin
            flat_key = (m < 2) ? 56'h0 : 56'hFFFFFFFFFFFFFF;
            flat_exp = (m < 2) ? 48'h0 : 48'hFFFFFFFFFFFF;
            applyStimulus(flat_key, m[0]);
            wait_done(100, 1'b1);
            for (int j = 0; j < 16; j++) checkOutput("flat_subkey", got_key[j], flat_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
